// File: rtl/vector_edisk_ctrl.sv
// Multi-board E-disk controller: per-board config latches, CPU-cycle to SDRAM
// address translation, and a request/ack handshake towards the SDRAM wrapper.
module vector_edisk_ctrl #(
    parameter int         NUM_DISKS = 1,
    parameter logic [7:0] BASE_PORT = 8'h10,
    parameter int         ADDR_W    = 25,
    localparam int        PAGE_W    = $clog2(4*NUM_DISKS+1)
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              io_wr,
    input  logic [7:0]        io_addr,
    input  logic [7:0]        io_din,
    input  logic [15:0]       cpu_addr,
    input  logic              ram_read,
    input  logic              write_n,
    input  logic              io_stack,
    input  logic              mem_req,
    input  logic              mem_we,
    output logic              out_req,
    output logic              out_we,
    output logic [ADDR_W-1:0] out_addr,
    input  logic              out_ack,
    output logic              mem_ack,
    output logic [PAGE_W-1:0] ed_page,
    output logic              conflict,
    input  logic              conflict_clr
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_XLATE = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic              io_wr_d;
    logic [7:0]        cfg [NUM_DISKS];
    logic [15:0]       a_q;
    logic              rd_q, wn_q, stk_q, we_q;
    logic [PAGE_W-1:0] page_x;
    logic [3:0]        n_hit;

    // One config write per io_wr rising edge; held strobes do not re-write.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            io_wr_d <= 1'b0;
            for (int unsigned i = 0; i < unsigned'(NUM_DISKS); i++)
                cfg[i] <= '0;
        end else begin
            io_wr_d <= io_wr;
            if (io_wr && !io_wr_d) begin
                for (int unsigned i = 0; i < unsigned'(NUM_DISKS); i++)
                    if (io_addr == BASE_PORT + 8'(i))
                        cfg[i] <= io_din;
            end
        end
    end

    // Translation reads cfg before any same-cycle config update lands.
    always_comb begin : xlate
        logic [7:0] c;
        logic       mcyc, win, hs, hw, found;
        page_x = '0;
        n_hit  = '0;
        found  = 1'b0;
        c      = '0;
        win    = 1'b0;
        hs     = 1'b0;
        hw     = 1'b0;
        mcyc   = rd_q | ~wn_q;
        for (int unsigned i = 0; i < unsigned'(NUM_DISKS); i++) begin
            c   = cfg[i];
            win = a_q[15] & ((a_q[13] ^ a_q[14]) | (c[7] & a_q[13] & a_q[14])
                             | (c[6] & ~a_q[13] & ~a_q[14]));
            hs  = c[4] & stk_q & mcyc;
            hw  = c[5] & win & mcyc;
            if (hs || hw) begin
                n_hit = n_hit + 4'd1;
                if (!found) begin
                    found  = 1'b1;
                    page_x = PAGE_W'(1 + 4*i + (hs ? c[3:2] : c[1:0]));
                end
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            a_q      <= '0;
            rd_q     <= 1'b0;
            wn_q     <= 1'b1;
            stk_q    <= 1'b0;
            we_q     <= 1'b0;
            out_req  <= 1'b0;
            out_we   <= 1'b0;
            out_addr <= '0;
            mem_ack  <= 1'b0;
            ed_page  <= '0;
            conflict <= 1'b0;
        end else begin
            mem_ack <= 1'b0;
            if (conflict_clr)
                conflict <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mem_req) begin
                        a_q   <= cpu_addr;
                        rd_q  <= ram_read;
                        wn_q  <= write_n;
                        stk_q <= io_stack;
                        we_q  <= mem_we;
                        state <= S_XLATE;
                    end
                end
                S_XLATE: begin
                    ed_page  <= page_x;
                    out_addr <= ADDR_W'({page_x, a_q});
                    out_we   <= we_q;
                    out_req  <= 1'b1;
                    if (n_hit > 4'd1)
                        conflict <= 1'b1;
                    state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (out_ack) begin
                        out_req <= 1'b0;
                        mem_ack <= 1'b1;
                        state   <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_edisk_ctrl.sv
// Scoreboard bench for vector_edisk_ctrl with two boards: stimulus pushes
// expected translations, a monitor pops them on each mem_ack.
module tb_vector_edisk_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        io_wr;
    logic [7:0]  io_addr, io_din;
    logic [15:0] cpu_addr;
    logic        ram_read, write_n, io_stack, mem_req, mem_we;
    logic        out_req, out_we, out_ack, mem_ack, conflict, conflict_clr;
    logic [24:0] out_addr;
    logic [3:0]  ed_page;

    vector_edisk_ctrl #(.NUM_DISKS(2), .BASE_PORT(8'h10), .ADDR_W(25)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .io_wr(io_wr), .io_addr(io_addr),
        .io_din(io_din), .cpu_addr(cpu_addr), .ram_read(ram_read), .write_n(write_n),
        .io_stack(io_stack), .mem_req(mem_req), .mem_we(mem_we), .out_req(out_req),
        .out_we(out_we), .out_addr(out_addr), .out_ack(out_ack), .mem_ack(mem_ack),
        .ed_page(ed_page), .conflict(conflict), .conflict_clr(conflict_clr)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [24:0] addr;
        logic        we;
        logic [3:0]  page;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;
    int unsigned n_acks = 0;
    int unsigned ack_delay = 0;
    logic        ack_low_chk = 1'b0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every completed access against the scoreboard head.
    always @(negedge clk_sys) begin
        if (ack_low_chk) begin
            check("mem_ack_single_pulse", {31'd0, mem_ack}, 32'd0);
            ack_low_chk = 1'b0;
        end else if (reset_n && mem_ack) begin
            n_acks++;
            ack_low_chk = 1'b1;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ack: got mem_ack with empty scoreboard at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_addr", {7'd0, out_addr}, {7'd0, e.addr});
                check("out_we", {31'd0, out_we}, {31'd0, e.we});
                check("ed_page", {28'd0, ed_page}, {28'd0, e.page});
                check("ack_latency", cyc, e.cyc);
            end
        end
    end

    // SDRAM responder: acks after ack_delay cycles, checking request stability meanwhile.
    initial begin
        logic [24:0] a0;
        logic        aborted;
        out_ack = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (reset_n && out_req) begin
                a0 = out_addr;
                aborted = 1'b0;
                for (int unsigned k = 0; k < ack_delay; k++) begin
                    @(negedge clk_sys);
                    if (!reset_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    check("out_req_held", {31'd0, out_req}, 32'd1);
                    check("out_addr_stable", {7'd0, out_addr}, {7'd0, a0});
                end
                if (!aborted) begin
                    out_ack = 1'b1;
                    @(negedge clk_sys);
                    out_ack = 1'b0;
                end
            end
        end
    end

    task automatic cfg_write(input logic [7:0] port, input logic [7:0] data);
        @(posedge clk_sys); #1;
        io_addr = port; io_din = data; io_wr = 1'b1;
        @(posedge clk_sys); #1;
        io_wr = 1'b0;
        @(posedge clk_sys);
    endtask

    task automatic access(input logic [15:0] a, input logic rd, input logic wn,
                          input logic stk, input logic we, input logic [3:0] pg,
                          input int unsigned d);
        exp_t        e;
        int unsigned start;
        @(posedge clk_sys); #1;
        cpu_addr = a; ram_read = rd; write_n = wn; io_stack = stk; mem_we = we;
        ack_delay = d;
        mem_req = 1'b1;
        e.addr = {5'd0, pg, a};
        e.we   = we;
        e.page = pg;
        e.cyc  = cyc + 3 + d;
        sb.push_back(e);
        start = n_acks;
        @(posedge clk_sys); #1;
        mem_req = 1'b0;
        for (int k = 0; k < 60 && n_acks == start; k++) @(posedge clk_sys);
        check("ack_seen", {31'd0, n_acks != start}, 32'd1);
        if (n_acks == start) sb.delete();
        @(posedge clk_sys);
    endtask

    initial begin
        reset_n = 1'b0; io_wr = 1'b0; io_addr = '0; io_din = '0; cpu_addr = '0;
        ram_read = 1'b0; write_n = 1'b1; io_stack = 1'b0; mem_req = 1'b0;
        mem_we = 1'b0; conflict_clr = 1'b0;
        repeat (3) @(negedge clk_sys);
        #1;
        check("rst_out_req", {31'd0, out_req}, 32'd0);
        check("rst_mem_ack", {31'd0, mem_ack}, 32'd0);
        check("rst_conflict", {31'd0, conflict}, 32'd0);
        check("rst_ed_page", {28'd0, ed_page}, 32'd0);
        check("rst_out_addr", {7'd0, out_addr}, 32'd0);
        @(negedge clk_sys);
        reset_n = 1'b1;

        // Board 1 RAM window, bank 1 -> page 6 only in the A000/C000 window
        cfg_write(8'h11, 8'h21);
        access(16'hA000, 1'b1, 1'b1, 1'b0, 1'b0, 4'd6, 0);
        access(16'h8000, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 0);

        // Board 0 stack, bank 3 -> page 4
        cfg_write(8'h10, 8'h1C);
        access(16'h1234, 1'b1, 1'b1, 1'b1, 1'b0, 4'd4, 0);
        access(16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 0);
        access(16'h1234, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 0);
        access(16'h1234, 1'b0, 1'b0, 1'b1, 1'b1, 4'd4, 0);

        // Both boards hit the window: lowest board wins, conflict flagged
        check("conflict_before", {31'd0, conflict}, 32'd0);
        cfg_write(8'h10, 8'h20);
        cfg_write(8'h11, 8'h20);
        access(16'hA000, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 0);
        check("conflict_set", {31'd0, conflict}, 32'd1);
        @(posedge clk_sys); #1;
        conflict_clr = 1'b1;
        @(posedge clk_sys); #1;
        conflict_clr = 1'b0;
        check("conflict_clr", {31'd0, conflict}, 32'd0);

        // Held io_wr: only the first-edge data is latched
        @(posedge clk_sys); #1;
        io_addr = 8'h10; io_din = 8'h1D; io_wr = 1'b1;
        for (int k = 1; k < 10; k++) begin
            @(posedge clk_sys); #1;
            io_din = 8'(k);
        end
        @(posedge clk_sys); #1;
        io_wr = 1'b0;
        access(16'h1234, 1'b1, 1'b1, 1'b1, 1'b0, 4'd4, 0);

        // Slow SDRAM: board 1 window bank 0 -> page 5, 7-cycle ack delay
        access(16'hA000, 1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 7);
        check("conflict_after_single", {31'd0, conflict}, 32'd0);

        // Reset in the middle of ISSUE abandons the access and clears config
        @(posedge clk_sys); #1;
        cpu_addr = 16'hA000; ram_read = 1'b1; write_n = 1'b1; io_stack = 1'b0;
        mem_we = 1'b0; ack_delay = 20; mem_req = 1'b1;
        @(posedge clk_sys); #1;
        mem_req = 1'b0;
        for (int k = 0; k < 20 && !out_req; k++) @(negedge clk_sys);
        check("issue_out_req", {31'd0, out_req}, 32'd1);
        @(negedge clk_sys); #2;
        reset_n = 1'b0;
        #1;
        check("midrst_out_req", {31'd0, out_req}, 32'd0);
        check("midrst_ed_page", {28'd0, ed_page}, 32'd0);
        check("midrst_out_addr", {7'd0, out_addr}, 32'd0);
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (2) @(posedge clk_sys);
        access(16'hA000, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 0);
        access(16'h1234, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 0);

        repeat (3) @(posedge clk_sys);
        check("sb_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
